// File: rtl/jseq_pkg.sv
// Shared types and constants for the Johnson step sequencer.
// Holds the FSM state enum, the direction encodings and the phase index width helper.
// No logic, so no latency or backpressure of its own.
package jseq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // A Johnson counter of width w has 2*w states. The index is kept at least 1 bit wide.
  function automatic int jseq_idx_w(input int width);
    int w;
    w = $clog2(2 * width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/johnson_core.sv
// Johnson register only: shifts one position per enabled cycle in the given direction.
// Latency: a shift or clear lands on the edge after en/clr is sampled.
// No backpressure; clr has priority over en, and count holds when neither is set.
module johnson_core
  import jseq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // Next value: clear wins, otherwise an enabled forward or reverse Johnson shift.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      if (dir == DIR_REV) begin
        count_d = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
      end else begin
        count_d = {~count_q[0], count_q[WIDTH-1:1]};
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/johnson_step_sequencer.sv
// Runs a Johnson counter for a programmed number of steps under a start/busy/done handshake, with phase decode.
// Latency: first shift one edge after start; done is high the cycle after the last shift; the decode is combinational.
// Backpressure: hold stalls shifting, abort ends the run without done. Build with JSEQ_SELFCHECK_EN for the legality check and err output.
module johnson_step_sequencer
  import jseq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  localparam int IDX_W = jseq_idx_w(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_steps,
  input  logic               dir,
  input  logic               hold,
  input  logic               abort,
  input  logic               clr,
  output logic               busy,
  output logic               done,
  output logic               wrap,
  output logic [WIDTH-1:0]   count,
  output logic [2*WIDTH-1:0] phase,
  output logic [IDX_W-1:0]   phase_idx
`ifdef JSEQ_SELFCHECK_EN
  ,
  output logic               err
`endif
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_e           state_d, state_q;
  logic [CNT_W-1:0] steps_d, steps_q;
  logic             dir_d, dir_q;
  logic             wrap_d, wrap_q;
  logic             core_en;
  logic             core_clr;
  logic [WIDTH-1:0] shifted;
  logic [2*WIDTH-1:0] phase_c;
  logic [IDX_W-1:0]   idx_c;
`ifdef JSEQ_SELFCHECK_EN
  logic             legal;
  logic             err_d, err_q;
`endif

  johnson_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk  (clk),
    .reset(reset),
    .en   (core_en),
    .dir  (dir_q),
    .clr  (core_clr),
    .count(count)
  );

  // Value the core would take if it shifted this cycle; used to spot a landing on all-zero.
  always_comb begin
    if (dir_q == DIR_REV) begin
      shifted = {count[WIDTH-2:0], ~count[WIDTH-1]};
    end else begin
      shifted = {~count[0], count[WIDTH-1:1]};
    end
  end

  // Decode count against each forward-sequence pattern; no match leaves phase and index at 0.
  always_comb begin
    logic [WIDTH-1:0] pat;
    phase_c = '0;
    idx_c   = '0;
    pat     = '0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      if (i <= WIDTH) begin
        pat = ~(ALL_ONES >> i);
      end else begin
        pat = ALL_ONES >> (i - WIDTH);
      end
      if (count == pat) begin
        phase_c[i] = 1'b1;
        idx_c      = IDX_W'(i);
      end
    end
  end

`ifdef JSEQ_SELFCHECK_EN
  assign legal = |phase_c;
`endif

  // Sequencer FSM: launch, step counting, stall/abort handling and core control.
  always_comb begin
    state_d  = state_q;
    steps_d  = steps_q;
    dir_d    = dir_q;
    core_en  = 1'b0;
    core_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr) begin
          core_clr = 1'b1;
        end else if (start) begin
          if (num_steps != '0) begin
            dir_d   = dir;
            steps_d = num_steps;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!hold) begin
          core_en = 1'b1;
          steps_d = steps_q - CNT_W'(1);
          if (steps_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef JSEQ_SELFCHECK_EN
    // An illegal count is scrubbed to zero and the run is dropped without done.
    if (!legal) begin
      core_en  = 1'b0;
      core_clr = 1'b1;
      state_d  = IDLE;
    end
`endif
    wrap_d = core_en && (shifted == '0);
  end

`ifdef JSEQ_SELFCHECK_EN
  // Sticky error flag, set on the first illegal count seen.
  always_comb begin
    err_d = err_q | ~legal;
  end
`endif

  // Control registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      steps_q <= '0;
      dir_q   <= DIR_FWD;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      steps_q <= steps_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef JSEQ_SELFCHECK_EN
  // Error flag register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign wrap      = wrap_q;
  assign phase     = phase_c;
  assign phase_idx = idx_c;

endmodule

// File: tb/tb_johnson_step_sequencer.sv
// Directed bench for johnson_step_sequencer with WIDTH=4, CNT_W=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// Expected values are hand-derived from the forward sequence 0,8,C,E,F,7,3,1.
module tb_johnson_step_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] num_steps;
  logic       dir;
  logic       hold;
  logic       abort;
  logic       clr;
  logic       busy;
  logic       done;
  logic       wrap;
  logic [3:0] count;
  logic [7:0] phase;
  logic [2:0] phase_idx;

  int passed;
  int total;

  johnson_step_sequencer #(
    .WIDTH(4),
    .CNT_W(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .num_steps(num_steps),
    .dir      (dir),
    .hold     (hold),
    .abort    (abort),
    .clr      (clr),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap),
    .count    (count),
    .phase    (phase),
    .phase_idx(phase_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] fwd_seq [8];
  logic [3:0] rev_cnt [3];
  logic [2:0] rev_idx [3];

  initial begin
    passed = 0;
    total  = 0;
    fwd_seq = '{4'h8, 4'hC, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1, 4'h0};
    rev_cnt = '{4'h1, 4'h3, 4'h7};
    rev_idx = '{3'd7, 3'd6, 3'd5};

    reset = 1'b0; start = 1'b0; num_steps = '0; dir = 1'b0;
    hold = 1'b0; abort = 1'b0; clr = 1'b0;

    // Reset values while reset is low.
    step(); step(); step();
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_phase", 32'(phase), 32'h01);
    chk("rst_idx", 32'(phase_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);

    // Releasing reset changes nothing while idle.
    reset = 1'b1;
    step(); step();
    chk("rel_count", 32'(count), 32'h0);
    chk("rel_phase", 32'(phase), 32'h01);
    chk("rel_busy", 32'(busy), 32'd0);

    // Full forward lap of 8 steps.
    start = 1'b1; num_steps = 8'd8; dir = 1'b0;
    step();
    start = 1'b0; num_steps = '0;
    chk("lap_busy0", 32'(busy), 32'd1);
    chk("lap_count0", 32'(count), 32'h0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("lap_count%0d", i + 1), 32'(count), 32'(fwd_seq[i]));
      chk($sformatf("lap_phase%0d", i + 1), 32'(phase), 32'h1 << ((i + 1) % 8));
      chk($sformatf("lap_wrap%0d", i + 1), 32'(wrap), (i == 7) ? 32'd1 : 32'd0);
      chk($sformatf("lap_busy%0d", i + 1), 32'(busy), (i == 7) ? 32'd0 : 32'd1);
      chk($sformatf("lap_done%0d", i + 1), 32'(done), (i == 7) ? 32'd1 : 32'd0);
    end
    step();
    chk("lap_done_end", 32'(done), 32'd0);
    chk("lap_wrap_end", 32'(wrap), 32'd0);
    chk("lap_busy_end", 32'(busy), 32'd0);

    // Reverse run of 3 from 0000.
    start = 1'b1; num_steps = 8'd3; dir = 1'b1;
    step();
    start = 1'b0; dir = 1'b0; num_steps = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rev_count%0d", i), 32'(count), 32'(rev_cnt[i]));
      chk($sformatf("rev_idx%0d", i), 32'(phase_idx), 32'(rev_idx[i]));
      chk($sformatf("rev_wrap%0d", i), 32'(wrap), 32'd0);
    end
    chk("rev_phase", 32'(phase), 32'h20);
    chk("rev_done", 32'(done), 32'd1);
    step();

    // clr together with start: clr wins and count returns to zero.
    clr = 1'b1; start = 1'b1; num_steps = 8'd5;
    step();
    clr = 1'b0; start = 1'b0; num_steps = '0;
    chk("clr_count", 32'(count), 32'h0);
    chk("clr_busy", 32'(busy), 32'd0);
    step();
    chk("clr_busy2", 32'(busy), 32'd0);
    chk("clr_done", 32'(done), 32'd0);

    // Hold for 2 cycles after the 2nd shift of a 5-step run.
    start = 1'b1; num_steps = 8'd5; dir = 1'b0;
    step();
    start = 1'b0; num_steps = '0;
    step();
    chk("hold_s1", 32'(count), 32'h8);
    step();
    chk("hold_s2", 32'(count), 32'hC);
    hold = 1'b1;
    step();
    chk("hold_h1", 32'(count), 32'hC);
    chk("hold_busy1", 32'(busy), 32'd1);
    step();
    chk("hold_h2", 32'(count), 32'hC);
    chk("hold_busy2", 32'(busy), 32'd1);
    hold = 1'b0;
    step();
    chk("hold_s3", 32'(count), 32'hE);
    step();
    chk("hold_s4", 32'(count), 32'hF);
    chk("hold_done_early", 32'(done), 32'd0);
    step();
    chk("hold_s5", 32'(count), 32'h7);
    chk("hold_done", 32'(done), 32'd1);
    step();

    // Abort on the final step of a 4-step run; start during busy is ignored.
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("ab_clr", 32'(count), 32'h0);
    start = 1'b1; num_steps = 8'd4; dir = 1'b0;
    step();
    num_steps = 8'd9; dir = 1'b1;
    step();
    chk("ab_s1", 32'(count), 32'h8);
    step();
    chk("ab_s2", 32'(count), 32'hC);
    start = 1'b0; num_steps = '0; dir = 1'b0;
    step();
    chk("ab_s3", 32'(count), 32'hE);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_count", 32'(count), 32'hE);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_done", 32'(done), 32'd0);
    step();
    chk("ab_count2", 32'(count), 32'hE);
    chk("ab_done2", 32'(done), 32'd0);

    // Zero-step start: done next cycle, no shift.
    start = 1'b1; num_steps = 8'd0;
    step();
    start = 1'b0;
    chk("z_done", 32'(done), 32'd1);
    chk("z_busy", 32'(busy), 32'd0);
    chk("z_count", 32'(count), 32'hE);
    step();
    chk("z_done2", 32'(done), 32'd0);
    chk("z_count2", 32'(count), 32'hE);

    // Reset asserted mid-run returns to reset values at once.
    start = 1'b1; num_steps = 8'd10; dir = 1'b0;
    step();
    start = 1'b0; num_steps = '0;
    step();
    chk("mr_s1", 32'(count), 32'hF);
    step();
    chk("mr_s2", 32'(count), 32'h7);
    chk("mr_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mr_count", 32'(count), 32'h0);
    chk("mr_busy0", 32'(busy), 32'd0);
    chk("mr_phase", 32'(phase), 32'h01);
    step();
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_wrap", 32'(wrap), 32'd0);
    reset = 1'b1;
    step();
    chk("mr_idle_busy", 32'(busy), 32'd0);
    chk("mr_idle_done", 32'(done), 32'd0);
    chk("mr_idle_count", 32'(count), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
